// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: consumes the prediction queue head, compares it with the
// execute-stage outcome, and sequences fetch redirect plus pipeline flush on a mispredict.
module branch_resolve_unit #(
  parameter int DEPTH        = 3,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_WIDTH    = 16,
  localparam int OCC_W       = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall,
  input  logic                 pred_load,
  input  logic                 q_prediction,
  input  logic [15:0]          q_mispredict_address,
  input  logic                 br_valid,
  input  logic                 br_taken,
  output logic                 update_predictions,
  output logic                 correct_prediction,
  output logic                 redirect_valid,
  output logic [15:0]          redirect_pc,
  output logic                 flush,
  output logic [OCC_W-1:0]     occupancy,
  output logic [CNT_WIDTH-1:0] branch_count,
  output logic [CNT_WIDTH-1:0] mispredict_count,
  output logic                 underflow_err,
  output logic                 overflow_err
);

  typedef enum logic [1:0] {RUN, REDIRECT, FLUSH} state_t;

  localparam logic [OCC_W-1:0] OCC_MAX    = OCC_W'(DEPTH);
  localparam logic [3:0]       FLUSH_INIT = 4'(FLUSH_CYCLES);

  state_t                 r_state, w_state_nxt;
  logic [3:0]             r_flush_cnt, w_flush_cnt_nxt;
  logic [OCC_W-1:0]       r_occ, w_occ_nxt;
  logic [15:0]            r_redirect_pc;
  logic [CNT_WIDTH-1:0]   r_branch_cnt, r_mispredict_cnt;
  logic                   r_underflow, r_overflow;
  logic                   w_run, w_resolve, w_correct, w_mispredict;
  logic                   w_underflow, w_overflow;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    w_run        = rst_n & ~stall & (r_state == RUN);
    w_resolve    = w_run & br_valid & (r_occ != '0);
    w_correct    = w_resolve & (br_taken == q_prediction);
    w_mispredict = w_resolve & ~w_correct;
    // An empty-queue resolve is a protocol error, never a real branch
    w_underflow  = w_run & br_valid & (r_occ == '0);
    w_overflow   = w_run & pred_load & (r_occ == OCC_MAX) & ~w_correct;
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_flush_cnt_nxt = r_flush_cnt;
    if (!stall) begin
      case (r_state)
        RUN: if (w_mispredict) w_state_nxt = REDIRECT;
        REDIRECT: begin
          w_state_nxt     = FLUSH;
          w_flush_cnt_nxt = FLUSH_INIT;
        end
        FLUSH: begin
          if (r_flush_cnt <= 4'd1) begin
            w_state_nxt     = RUN;
            w_flush_cnt_nxt = '0;
          end else begin
            w_flush_cnt_nxt = r_flush_cnt - 1'b1;
          end
        end
        default: w_state_nxt = RUN;
      endcase
    end
  end

  always_comb begin
    w_occ_nxt = r_occ;
    if (w_run) begin
      if (w_mispredict)                        w_occ_nxt = '0;
      else if (w_correct && !pred_load)        w_occ_nxt = r_occ - 1'b1;
      else if (!w_correct && pred_load && r_occ != OCC_MAX)
                                               w_occ_nxt = r_occ + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= RUN;
      r_flush_cnt      <= '0;
      r_occ            <= '0;
      r_redirect_pc    <= '0;
      r_branch_cnt     <= '0;
      r_mispredict_cnt <= '0;
      r_underflow      <= 1'b0;
      r_overflow       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
      r_occ       <= w_occ_nxt;
      if (w_mispredict) r_redirect_pc <= q_mispredict_address;
      if (w_resolve)    r_branch_cnt <= sat_inc(r_branch_cnt);
      if (w_mispredict) r_mispredict_cnt <= sat_inc(r_mispredict_cnt);
      if (w_underflow)  r_underflow <= 1'b1;
      if (w_overflow)   r_overflow  <= 1'b1;
    end
  end

  assign update_predictions = w_resolve;
  assign correct_prediction = w_correct;
  assign redirect_valid     = (r_state == REDIRECT);
  assign flush              = (r_state == REDIRECT) | (r_state == FLUSH);
  assign redirect_pc        = r_redirect_pc;
  assign occupancy          = r_occ;
  assign branch_count       = r_branch_cnt;
  assign mispredict_count   = r_mispredict_cnt;
  assign underflow_err      = r_underflow;
  assign overflow_err       = r_overflow;

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Consumer end of the branch prediction queue.
- Takes the queue head (prediction bit, alternate-path address) and the execute-stage branch outcome.
- Generates the queue's update_predictions / correct_prediction controls, tracks queue occupancy, and on a mispredict issues a registered fetch redirect followed by a timed pipeline flush.
- Keeps saturating branch/mispredict statistics.

Parameters:
- DEPTH, 3: prediction queue capacity; occupancy counter width is $clog2(DEPTH+1).
- FLUSH_CYCLES, 2: cycles of flush asserted after the redirect cycle; legal range 1..15.
- CNT_WIDTH, 16: width of the statistics counters.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  pipeline stall; freezes all state.
- pred_load  in  1  fetch pushed a prediction into the queue this cycle.
- q_prediction  in  1  queue head predicted direction (1 = taken).
- q_mispredict_address  in  16  queue head alternate-path PC.
- br_valid  in  1  execute stage resolves a conditional branch this cycle.
- br_taken  in  1  actual branch direction.
- update_predictions  out  1  pop/clear request to queue (combinational).
- correct_prediction  out  1  head prediction matched (combinational).
- redirect_valid  out  1  fetch redirect request (registered).
- redirect_pc  out  16  redirect target (registered).
- flush  out  1  squash younger pipeline stages (registered).
- occupancy  out  $clog2(DEPTH+1)  predictions outstanding.
- branch_count  out  CNT_WIDTH  resolved branches.
- mispredict_count  out  CNT_WIDTH  mispredicted branches.
- underflow_err  out  1  sticky; branch resolved with empty queue.
- overflow_err  out  1  sticky; pred_load with queue full.

Behaviour:
- Reset (async, rst_n=0): state RUN; redirect_valid=0, redirect_pc=0, flush=0, occupancy=0, both counters 0, both error flags 0. Combinational outputs are forced 0 while rst_n=0.
- resolve = br_valid & ~stall & state==RUN & occupancy!=0.
- update_predictions = resolve.
- correct_prediction = resolve & (br_taken == q_prediction).
- mispredict = resolve & ~correct_prediction.
- stall=1: no register changes in any state. Combinational outputs are 0. Registered outputs hold their values.
- States:
  - RUN: flush=0, redirect_valid=0. On mispredict: latch redirect_pc <= q_mispredict_address, go to REDIRECT.
  - REDIRECT (exactly 1 unstalled cycle): redirect_valid=1, flush=1. Then go to FLUSH with flush counter = FLUSH_CYCLES.
  - FLUSH: flush=1, redirect_valid=0. The counter decrements on each unstalled cycle. Return to RUN on the cycle the counter reaches 0.
- Outputs are Moore, so redirect_valid and flush assert the cycle after the mispredicting resolve. Total flush length = 1 + FLUSH_CYCLES cycles.
- br_valid and pred_load are ignored in REDIRECT/FLUSH: they are wrong-path. No update, no counting, occupancy held at 0.
- Occupancy (RUN, unstalled):
  - mispredict -> 0. A same-cycle pred_load is dropped.
  - correct & pred_load -> unchanged.
  - correct only -> minus 1.
  - pred_load only -> plus 1, saturating at DEPTH.
  - pred_load while occupancy==DEPTH and not correct -> overflow_err <= 1, occupancy stays DEPTH.
- br_valid in RUN with occupancy==0 (unstalled): underflow_err <= 1. No update, no redirect, no counting.
- branch_count increments on every resolve. mispredict_count increments on every mispredict. Both saturate at all-ones, with no wrap.
- Error flags clear only on reset.
- Reset asserted mid-REDIRECT/FLUSH returns to RUN immediately, with flush and redirect_valid dropping asynchronously.

Test Plan:
- Reset then 3 pred_load pulses -> occupancy 1,2,3. A 4th pred_load -> occupancy 3, overflow_err=1.
- occupancy=2, br_valid=1, br_taken=1, q_prediction=1 -> same cycle update_predictions=1 and correct_prediction=1. Next cycle occupancy=1, branch_count=1, no flush.
- occupancy=2, br_taken=0, q_prediction=1, q_mispredict_address=16'h0124 -> correct_prediction=0. Next cycle redirect_valid=1, redirect_pc=16'h0124, flush=1. Then flush=1 for exactly 2 more cycles. occupancy=0, mispredict_count=1. br_valid during the flush window is ignored.
- stall=1 held 3 cycles during FLUSH -> flush stays 1, counter frozen. Total flush-high cycles = 3 + 3 stalled cycles. stall together with br_valid in RUN -> update_predictions=0, no state change.
- occupancy=0, br_valid=1 -> update_predictions=0, underflow_err=1 (sticky), counters unchanged. Same-cycle correct resolve + pred_load at occupancy 2 -> occupancy stays 2.
- Force branch_count to 16'hFFFE via 2 further resolves from 16'hFFFC... (or run 65537 resolves) -> saturates at 16'hFFFF. rst_n pulsed low mid-FLUSH -> flush=0 immediately, all counters 0.
